// File: rtl/axis_wconv_arb.sv
`default_nettype none
// =============================================================================
// axis_wconv_arb : round-robin frame arbiter feeding a 192->256 width converter,
//                  zero-padding every frame to a multiple of 4 input beats.
// Revision       : 1.0
// =============================================================================
module axis_wconv_arb #(
  parameter int N = 2
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [N-1:0]     s_axis_tvalid,
  output logic [N-1:0]     s_axis_tready,
  input  logic [N*192-1:0] s_axis_tdata,
  input  logic [N-1:0]     s_axis_tlast,
  output logic             m_axis_tvalid,
  output logic [191:0]     m_axis_tdata,
  output logic             m_axis_tlast,
  output logic [2:0]       m_src,
  output logic [15:0]      pad_beats
);

  localparam int         DW       = 192;
  localparam logic [2:0] LAST_RST = 3'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    PAD    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] last_grant_q, last_grant_d;
  logic [1:0] phase_q, phase_d;

  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          m_last_q, m_last_d;
  logic [2:0]    m_src_q, m_src_d;
  logic [15:0]   pad_q, pad_d;

  logic          pick_found;
  logic [2:0]    pick;
  logic          sel_valid;
  logic          sel_last;
  logic [DW-1:0] sel_data;

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin : arb
    int cand;
    cand       = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int off = 1; off <= N; off++) begin
      cand = int'(last_grant_q) + off;
      if (cand >= N) cand = cand - N;
      if (!pick_found && s_axis_tvalid[cand]) begin
        pick_found = 1'b1;
        pick       = 3'(cand);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q == 3'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*DW +: DW];
      end
    end
  end

  // Ready is a pure function of registered state, never of tvalid.
  for (genvar i = 0; i < N; i++) begin : g_ready
    assign s_axis_tready[i] = (state_q == STREAM) && (grant_q == 3'(i));
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    phase_d      = phase_q;
    m_valid_d    = 1'b0;
    m_data_d     = m_data_q;
    m_last_d     = 1'b0;
    m_src_d      = m_src_q;
    pad_d        = pad_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d      = pick;
          last_grant_d = pick;
          state_d      = STREAM;
        end
      end
      STREAM: begin
        if (sel_valid) begin
          m_valid_d = 1'b1;
          m_data_d  = sel_data;
          m_src_d   = grant_q;
          phase_d   = phase_q + 2'd1;
          if (sel_last) begin
            if (phase_q == 2'd3) begin
              m_last_d = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d  = PAD;
            end
          end
        end
      end
      PAD: begin
        m_valid_d = 1'b1;
        m_data_d  = '0;
        m_src_d   = grant_q;
        phase_d   = phase_q + 2'd1;
        if (pad_q != 16'hFFFF) pad_d = pad_q + 16'd1;
        if (phase_q == 2'd3) begin
          m_last_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      phase_q      <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      m_src_q      <= '0;
      pad_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      phase_q      <= phase_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      m_src_q      <= m_src_d;
      pad_q        <= pad_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign m_src         = m_src_q;
  assign pad_beats     = pad_q;

endmodule
`default_nettype wire

// File: doc/axis_wconv_arb.md
# axis_wconv_arb

Round-robin frame arbiter and alignment sequencer that shares the single 192-to-256-bit width converter (192-bit in, valid-only, no backpressure) among N framed 192-bit AXI-Stream sources. The block grants one source per frame. It forwards that frame's beats to the converter input and pads each frame with zero beats up to a multiple of 4 input beats (768 bits = 3 output words). This keeps every frame starting on a converter output-word boundary. It sits directly upstream of the width converter.

## Interface
- N, default 2: number of requesting sources, 1..8.
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  N  per-source beat valid.
- s_axis_tready  out  N  per-source ready; at most one bit high.
- s_axis_tdata  in  N*192  source i occupies bits [192*i+191 : 192*i].
- s_axis_tlast  in  N  per-source end-of-frame.
- m_axis_tvalid  out  1  beat valid to converter input.
- m_axis_tdata  out  192  beat data to converter input.
- m_axis_tlast  out  1  high on last beat of a padded frame (real or pad beat).
- m_src  out  3  index of the granted source, valid while m_axis_tvalid.
- pad_beats  out  16  total pad beats inserted since reset, saturates at 0xFFFF.

## Operation
- The FSM has three states: IDLE, STREAM and PAD.
- Registers:
  - grant (3b), last_grant (reset N-1).
  - phase (2b, beats mod 4 in current frame, reset 0).
  - Output registers.
- IDLE:
  - s_axis_tready = 0.
  - If any s_axis_tvalid is high, select the first set bit searching from last_grant+1 cyclically.
  - Load grant and last_grant, then go to STREAM.
  - Otherwise stay in IDLE.
- STREAM:
  - s_axis_tready[grant] = 1; all other ready bits are 0.
  - The ready bits depend only on state and grant, never on tvalid.
  - An accepted beat (tvalid & tready) is registered to m_axis_tdata with m_axis_tvalid=1 and m_src=grant, and phase increments.
  - With no accepted beat: m_axis_tvalid=0 and phase holds.
  - Accepted beat with tlast, and phase+1 ≡ 0 mod 4: m_axis_tlast=1 on that beat, go to IDLE.
  - Accepted beat with tlast, otherwise: go to PAD.
- PAD:
  - All s_axis_tready = 0.
  - Each cycle emit m_axis_tvalid=1, m_axis_tdata=0, m_src=grant, increment phase and pad_beats (saturating).
  - When phase+1 ≡ 0, m_axis_tlast=1 on that pad beat; go to IDLE.
- Pad beats per frame = (4 − L mod 4) mod 4, where L is the frame length in beats. Values: 0, 1, 2 or 3.
- Non-granted sources are never dropped. They wait with tready low.
- N=1: arbitration degenerates to always granting source 0.

## Timing
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_src=0, pad_beats=0, state=IDLE, phase=0, last_grant=N-1.
- Reset is asynchronous. Assertion clears outputs immediately, regardless of clock.
- Latency:
  - An input beat accepted at edge k appears on m_axis at k+1 (registered).
  - Pad beats are back-to-back from the cycle after the tlast beat.
- Frame overhead:
  - The cycle after a frame's final output beat is IDLE.
  - If any request is pending, ready rises one cycle later.
  - Minimum 1 idle cycle between frames.
- Simultaneous requests are resolved round-robin. A source waits at most N−1 frames.
- tvalid bubbles in STREAM produce m_axis_tvalid=0 cycles. Phase and grant are unchanged.
- A source changing tdata or tvalid while not granted has no effect.
- Reset mid-frame or mid-PAD:
  - The partial frame is discarded and not padded.
  - After release, arbitration restarts with source 0 preferred.
- m_axis_tvalid has no backpressure. The converter consumes every asserted beat.

## Test plan
- **Single 4-beat frame.** After reset, source 0 sends a 4-beat frame, data 1..4, tvalid continuous, tlast on beat 4.
  - m_axis beats 1..4, each one cycle after acceptance.
  - m_axis_tlast on beat 4, no pad, pad_beats=0, m_src=0.
- **5-beat frame.** Source 0 sends a 5-beat frame, data 0xA..0xE.
  - 5 data beats, then 3 consecutive zero beats with tready all low.
  - m_axis_tlast on the 8th beat, pad_beats=3.
- **Concurrent requests.** N=2; both sources hold 2-beat frames valid from reset release.
  - Source 0 goes first (m_src=0, 2 data + 2 pad), then source 1 (m_src=1).
  - With both still requesting, grants alternate 0,1,0,1; no beat is ever accepted from the non-granted source.
- **Bubbles.** Source 0 sends a 6-beat frame with tvalid pattern 1,0,0,1,1,0,1,1,1.
  - m_axis_tvalid mirrors the accepted beats one cycle later.
  - Exactly 2 pad beats follow, pad_beats increments by 2.
- **Reset mid-PAD.** Send a 1-beat frame; assert areset during the second pad beat.
  - All outputs go to 0 asynchronously; the remaining pad is not emitted.
  - After release, source 1 and source 0 both request; source 0 is granted first with phase=0.
